hazard_scoreboard: RTL

- Parametrised successor to the fixed load-use hazard detector in the 5-stage pipeline.
- Keeps one latency countdown per architectural register. Any producer latency is supported: ALU, load, or a multi-cycle unit.
- Stalls the ID stage on RAW and WAW hazards and reports issue and occupancy status.
- Sits beside the IF/ID register. Its stall output drives the PC write enable and the IF/ID write enable, and bubbles ID/EX.

---
 rtl/hazard_scoreboard.sv | 99 +++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: one latency countdown per architectural register,
// stalling on RAW/WAW hazards against in-flight producers of any latency.
module hazard_scoreboard #(
    parameter int REG_ADDR_W         = 5,
    parameter int NUM_REGS           = 32,
    parameter int LAT_W              = 4,
    parameter int MAX_LAT            = 8,
    parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_wr_en,
    input  logic [REG_ADDR_W-1:0] id_wr_reg,
    input  logic [LAT_W-1:0]      id_lat,
    input  logic                  flush,
    input  logic                  flush_all,
    output logic                  stall,
    output logic                  issue,
    output logic [REG_ADDR_W:0]   pending_cnt,
    output logic                  busy
);
    localparam logic [LAT_W-1:0]    LatOne  = LAT_W'(1);
    localparam logic [LAT_W-1:0]    LatMax  = LAT_W'(MAX_LAT);
    localparam logic [REG_ADDR_W:0] NumRegs = (REG_ADDR_W+1)'(NUM_REGS);

    logic [LAT_W-1:0]    ctr_q [NUM_REGS];
    logic [LAT_W-1:0]    ctr_d [NUM_REGS];
    logic [REG_ADDR_W:0] pending_q, pending_d;
    logic                busy_q;
    logic [LAT_W-1:0]    lat_eff;
    logic [LAT_W-1:0]    rs_ctr, rt_ctr, wr_ctr;
    logic                raw_hazard, waw_hazard, hazard, live, do_load;

    function automatic logic is_tracked(input logic [REG_ADDR_W-1:0] r);
        return ({1'b0, r} < NumRegs) && !(ZERO_REG_HARDWIRED && (r == '0));
    endfunction

    assign rs_ctr = is_tracked(id_rs)     ? ctr_q[id_rs]     : '0;
    assign rt_ctr = is_tracked(id_rt)     ? ctr_q[id_rt]     : '0;
    assign wr_ctr = is_tracked(id_wr_reg) ? ctr_q[id_wr_reg] : '0;

    always_comb begin
        if (id_lat == '0) begin
            lat_eff = LatOne;
        end else if (id_lat > LatMax) begin
            lat_eff = LatMax;
        end else begin
            lat_eff = id_lat;
        end
    end

    // A counter of exactly 1 means the value is forwardable next cycle, so it is not a RAW hazard.
    assign raw_hazard = (id_uses_rs && (rs_ctr > LatOne)) || (id_uses_rt && (rt_ctr > LatOne));
    assign waw_hazard = id_wr_en && (wr_ctr > lat_eff);
    assign hazard     = raw_hazard || waw_hazard;
    assign live       = rst && id_valid && !flush && !flush_all;
    assign stall      = live && hazard;
    assign issue      = live && !hazard;
    assign do_load    = issue && id_wr_en && is_tracked(id_wr_reg);

    always_comb begin
        pending_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            ctr_d[i] = (ctr_q[i] != '0) ? (ctr_q[i] - LatOne) : '0;
            if (do_load && (id_wr_reg == REG_ADDR_W'(i))) begin
                ctr_d[i] = lat_eff;
            end
            if (flush_all) begin
                ctr_d[i] = '0;
            end
            pending_d = pending_d + {{REG_ADDR_W{1'b0}}, (ctr_d[i] != '0)};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                ctr_q[i] <= '0;
            end
            pending_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                ctr_q[i] <= ctr_d[i];
            end
            pending_q <= pending_d;
            busy_q    <= (pending_d != '0);
        end
    end

    assign pending_cnt = pending_q;
    assign busy        = busy_q;

endmodule
